axil_rd_ctrl: RTL and testbench

AXI4-Lite read-channel controller for the FIFO block. It accepts read addresses, decodes them against the FIFO address map and sequences the r_fifo pop. It returns RDATA/RRESP with a full VALID/READY handshake and drives the registered FIFO mode enables (rrr_en_w_fifo / rrr_en_r_fifo). It sits between the AXI slave interface and the w_fifo/r_fifo pair.

---
 rtl/axil_rd_ctrl_if.sv | 24 ++
 rtl/axil_rd_ctrl.sv | 141 ++++++++++++++
 tb/tb_axil_rd_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/axil_rd_ctrl_if.sv
// AXI4-Lite read-channel signal bundle (AR and R channels) shared by
// the read controller and its bus master.
interface axil_rd_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] ARADDR;
    logic              ARVALID;
    logic              ARREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;

    modport master (
        output ARADDR, ARVALID, RREADY,
        input  ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  ARADDR, ARVALID, RREADY,
        output ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axil_rd_ctrl.sv
// AXI4-Lite read controller for the w_fifo/r_fifo block: decodes status, level and
// pop addresses, sequences the r_fifo pop and drives the FIFO mode enables.
// Optional RD_TIMEOUT_EN: abandons a response after TIMEOUT_CYC cycles without RREADY.
module axil_rd_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int LVL_W       = 7,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    axil_rd_ctrl_if.slave     bus,
    input  logic [LVL_W-1:0]  w_fifo_level,
    input  logic [DATA_W-1:0] r_fifo_dout,
    input  logic              r_fifo_empty,
    output logic              r_fifo_rd_en,
    output logic              rrr_en_w_fifo,
    output logic              rrr_en_r_fifo
);
    localparam logic [ADDR_W-1:0] ADDR_STATUS = '0;
    localparam logic [ADDR_W-1:0] ADDR_LEVEL  = ADDR_W'(32'h0000_0010);
    localparam logic [ADDR_W-1:0] ADDR_POP    = ADDR_W'(32'h0000_0011);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, POP, WAIT, RESP} state_t;

    state_t      state;
    logic [7:0]  err_cnt;
    logic        tmo_flag;
    logic [31:0] status_word;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign status_word = {16'b0, err_cnt, 4'b0, tmo_flag, r_fifo_empty,
                          rrr_en_r_fifo, rrr_en_w_fifo};

`ifdef RD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign tmo_flag = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state         <= IDLE;
            bus.ARREADY   <= 1'b1;
            bus.RVALID    <= 1'b0;
            bus.RDATA     <= '0;
            bus.RRESP     <= RESP_OKAY;
            r_fifo_rd_en  <= 1'b0;
            rrr_en_w_fifo <= 1'b0;
            rrr_en_r_fifo <= 1'b0;
            err_cnt       <= 8'd0;
`ifdef RD_TIMEOUT_EN
            tmo_flag      <= 1'b0;
            tmo_cnt       <= '0;
`endif
        end else begin
            r_fifo_rd_en <= 1'b0;
            case (state)
                // ARREADY is always high here, so ARVALID alone marks the handshake
                IDLE: begin
                    if (bus.ARVALID) begin
                        bus.ARREADY <= 1'b0;
`ifdef RD_TIMEOUT_EN
                        tmo_cnt     <= '0;
`endif
                        if (bus.ARADDR == ADDR_STATUS) begin
                            bus.RDATA     <= DATA_W'(status_word);
                            bus.RRESP     <= RESP_OKAY;
                            bus.RVALID    <= 1'b1;
                            rrr_en_w_fifo <= 1'b0;
                            rrr_en_r_fifo <= 1'b0;
                            state         <= RESP;
                        end else if (bus.ARADDR == ADDR_LEVEL) begin
                            bus.RDATA     <= DATA_W'(w_fifo_level);
                            bus.RRESP     <= RESP_OKAY;
                            bus.RVALID    <= 1'b1;
                            rrr_en_w_fifo <= 1'b1;
                            rrr_en_r_fifo <= 1'b0;
                            state         <= RESP;
                        end else if (bus.ARADDR == ADDR_POP) begin
                            rrr_en_w_fifo <= 1'b0;
                            rrr_en_r_fifo <= 1'b1;
                            if (r_fifo_empty) begin
                                bus.RDATA  <= '0;
                                bus.RRESP  <= RESP_SLVERR;
                                bus.RVALID <= 1'b1;
                                err_cnt    <= sat_inc8(err_cnt);
                                state      <= RESP;
                            end else begin
                                r_fifo_rd_en <= 1'b1;
                                state        <= POP;
                            end
                        end else begin
                            bus.RDATA  <= '0;
                            bus.RRESP  <= RESP_DECERR;
                            bus.RVALID <= 1'b1;
                            err_cnt    <= sat_inc8(err_cnt);
                            state      <= RESP;
                        end
                    end
                end
                POP: state <= WAIT;
                // r_fifo_dout is valid the cycle after the pop strobe
                WAIT: begin
                    bus.RDATA  <= r_fifo_dout;
                    bus.RRESP  <= RESP_OKAY;
                    bus.RVALID <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (bus.RREADY) begin
                        bus.RVALID  <= 1'b0;
                        bus.ARREADY <= 1'b1;
                        state       <= IDLE;
                    end
`ifdef RD_TIMEOUT_EN
                    else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        bus.RVALID  <= 1'b0;
                        bus.ARREADY <= 1'b1;
                        tmo_flag    <= 1'b1;
                        err_cnt     <= sat_inc8(err_cnt);
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_rd_ctrl.sv
// Directed bench for axil_rd_ctrl: a vector table of single reads plus hand-written
// backpressure, timeout, error-saturation and mid-transaction reset sequences.
module tb_axil_rd_ctrl;
`ifdef RD_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 256;
`endif

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [6:0]  w_fifo_level;
    logic [31:0] r_fifo_dout = 32'hBAD0_BAD0;
    logic        r_fifo_empty;
    logic        r_fifo_rd_en;
    logic        rrr_en_w_fifo;
    logic        rrr_en_r_fifo;
    logic [31:0] fifo_word;

    int checks   = 0;
    int failures = 0;

    axil_rd_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    axil_rd_ctrl #(.DATA_W(32), .ADDR_W(32), .LVL_W(7), .TIMEOUT_CYC(TMO)) dut (
        .ACLK          (ACLK),
        .ARESETn       (ARESETn),
        .bus           (bus),
        .w_fifo_level  (w_fifo_level),
        .r_fifo_dout   (r_fifo_dout),
        .r_fifo_empty  (r_fifo_empty),
        .r_fifo_rd_en  (r_fifo_rd_en),
        .rrr_en_w_fifo (rrr_en_w_fifo),
        .rrr_en_r_fifo (rrr_en_r_fifo)
    );

    always #5 ACLK = ~ACLK;

    // r_fifo model: popped word appears on dout one cycle after the strobe
    always @(posedge ACLK) if (r_fifo_rd_en) r_fifo_dout <= fifo_word;

    typedef struct {
        logic [31:0] addr;
        logic [6:0]  level;
        logic        empty;
        logic [31:0] word;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        int          exp_lat;
        int          exp_popmask;
        logic        exp_en_w;
        logic        exp_en_r;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic rr,
                           output logic [31:0] rdata, output logic [1:0] rresp,
                           output int lat, output int popmask,
                           output logic ar1, output logic enw1, output logic enr1);
        int n;
        @(negedge ACLK);
        bus.ARADDR  = addr;
        bus.ARVALID = 1'b1;
        bus.RREADY  = rr;
        n = 0;
        while (!bus.ARREADY && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL ar_wait: ARREADY not seen within 50 cycles for addr 0x%08h", addr);
        end
        @(negedge ACLK);
        bus.ARVALID = 1'b0;
        ar1  = bus.ARREADY;
        enw1 = rrr_en_w_fifo;
        enr1 = rrr_en_r_fifo;
        lat = 1;
        popmask = 0;
        while (1) begin
            if (r_fifo_rd_en) popmask |= (1 << lat);
            if (bus.RVALID || lat >= 20) break;
            @(negedge ACLK);
            lat++;
        end
        rdata = bus.RDATA;
        rresp = bus.RRESP;
        if (rr) @(negedge ACLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        int          lat, pm, n, hold;
        logic        ar1, ew, er;

        vecs[0]  = '{32'h0000_0000, 7'd0,  1'b1, 32'h0,         32'h0000_0004, 2'b00, 1, 0, 1'b0, 1'b0};
        vecs[1]  = '{32'h0000_0010, 7'd37, 1'b1, 32'h0,         32'h0000_0025, 2'b00, 1, 0, 1'b1, 1'b0};
        vecs[2]  = '{32'h0000_0011, 7'd37, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00, 3, 2, 1'b0, 1'b1};
        vecs[3]  = '{32'h0000_0000, 7'd37, 1'b0, 32'h0,         32'h0000_0002, 2'b00, 1, 0, 1'b0, 1'b0};
        vecs[4]  = '{32'h0000_0011, 7'd37, 1'b1, 32'h0,         32'h0000_0000, 2'b10, 1, 0, 1'b0, 1'b1};
        vecs[5]  = '{32'h0000_0044, 7'd37, 1'b1, 32'h0,         32'h0000_0000, 2'b11, 1, 0, 1'b0, 1'b1};
        vecs[6]  = '{32'h0000_0000, 7'd37, 1'b1, 32'h0,         32'h0000_0206, 2'b00, 1, 0, 1'b0, 1'b0};
        vecs[7]  = '{32'h0000_0012, 7'd37, 1'b1, 32'h0,         32'h0000_0000, 2'b11, 1, 0, 1'b0, 1'b0};
        vecs[8]  = '{32'h8000_0010, 7'd37, 1'b1, 32'h0,         32'h0000_0000, 2'b11, 1, 0, 1'b0, 1'b0};
        vecs[9]  = '{32'h0000_0010, 7'd64, 1'b1, 32'h0,         32'h0000_0040, 2'b00, 1, 0, 1'b1, 1'b0};
        vecs[10] = '{32'h0000_0000, 7'd64, 1'b1, 32'h0,         32'h0000_0405, 2'b00, 1, 0, 1'b0, 1'b0};

        ARESETn      = 1'b0;
        bus.ARADDR   = '0;
        bus.ARVALID  = 1'b0;
        bus.RREADY   = 1'b0;
        w_fifo_level = '0;
        r_fifo_empty = 1'b1;
        fifo_word    = '0;
        repeat (2) @(negedge ACLK);
        chk("rst_arready", {31'b0, bus.ARREADY}, 32'd1);
        chk("rst_rvalid",  {31'b0, bus.RVALID}, 32'd0);
        chk("rst_rdata",   bus.RDATA, 32'd0);
        chk("rst_rresp",   {30'b0, bus.RRESP}, 32'd0);
        chk("rst_rd_en",   {31'b0, r_fifo_rd_en}, 32'd0);
        chk("rst_en_w",    {31'b0, rrr_en_w_fifo}, 32'd0);
        chk("rst_en_r",    {31'b0, rrr_en_r_fifo}, 32'd0);
        ARESETn = 1'b1;

        for (int i = 0; i < 11; i++) begin
            w_fifo_level = vecs[i].level;
            r_fifo_empty = vecs[i].empty;
            fifo_word    = vecs[i].word;
            do_read(vecs[i].addr, 1'b1, rd, rs, lat, pm, ar1, ew, er);
            chk($sformatf("v%0d_rdata", i),   rd, vecs[i].exp_data);
            chk($sformatf("v%0d_rresp", i),   {30'b0, rs}, {30'b0, vecs[i].exp_resp});
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_popmask", i), pm, vecs[i].exp_popmask);
            chk($sformatf("v%0d_arready_t1", i), {31'b0, ar1}, 32'd0);
            chk($sformatf("v%0d_en_w", i), {31'b0, ew}, {31'b0, vecs[i].exp_en_w});
            chk($sformatf("v%0d_en_r", i), {31'b0, er}, {31'b0, vecs[i].exp_en_r});
        end

        // Backpressure: response must hold steady while RREADY is low
        w_fifo_level = 7'd37;
        hold = (TMO > 10) ? 10 : 5;
        do_read(32'h10, 1'b0, rd, rs, lat, pm, ar1, ew, er);
        for (int c = 0; c < hold; c++) begin
            chk($sformatf("bp%0d_rvalid", c),  {31'b0, bus.RVALID}, 32'd1);
            chk($sformatf("bp%0d_rdata", c),   bus.RDATA, 32'h25);
            chk($sformatf("bp%0d_arready", c), {31'b0, bus.ARREADY}, 32'd0);
            @(negedge ACLK);
        end
        bus.RREADY = 1'b1;
        chk("bp_arready_at_rready", {31'b0, bus.ARREADY}, 32'd0);
        @(negedge ACLK);
        chk("bp_rvalid_after", {31'b0, bus.RVALID}, 32'd0);
        chk("bp_arready_after", {31'b0, bus.ARREADY}, 32'd1);

`ifdef RD_TIMEOUT_EN
        do_read(32'h10, 1'b0, rd, rs, lat, pm, ar1, ew, er);
        n = 0;
        while (bus.RVALID && n < 50) begin
            n++;
            @(negedge ACLK);
        end
        chk("tmo_rvalid_cycles", n, TMO);
        chk("tmo_arready", {31'b0, bus.ARREADY}, 32'd1);
        do_read(32'h0, 1'b1, rd, rs, lat, pm, ar1, ew, er);
        chk("tmo_status_bit3", {31'b0, rd[3]}, 32'd1);
`endif

        // Error counter saturates at 255
        for (int k = 0; k < 260; k++) do_read(32'h44, 1'b1, rd, rs, lat, pm, ar1, ew, er);
        do_read(32'h0, 1'b1, rd, rs, lat, pm, ar1, ew, er);
        chk("err_cnt_sat", {24'b0, rd[15:8]}, 32'hFF);

        // Reset during POP aborts everything immediately
        r_fifo_empty = 1'b0;
        fifo_word    = 32'hCAFE_F00D;
        @(negedge ACLK);
        bus.ARADDR  = 32'h11;
        bus.ARVALID = 1'b1;
        bus.RREADY  = 1'b1;
        @(negedge ACLK);
        bus.ARVALID = 1'b0;
        chk("pop_rd_en_before_rst", {31'b0, r_fifo_rd_en}, 32'd1);
        ARESETn = 1'b0;
        #1;
        chk("arst_arready", {31'b0, bus.ARREADY}, 32'd1);
        chk("arst_rvalid",  {31'b0, bus.RVALID}, 32'd0);
        chk("arst_rdata",   bus.RDATA, 32'd0);
        chk("arst_rresp",   {30'b0, bus.RRESP}, 32'd0);
        chk("arst_rd_en",   {31'b0, r_fifo_rd_en}, 32'd0);
        chk("arst_en_w",    {31'b0, rrr_en_w_fifo}, 32'd0);
        chk("arst_en_r",    {31'b0, rrr_en_r_fifo}, 32'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        r_fifo_empty = 1'b1;
        do_read(32'h0, 1'b1, rd, rs, lat, pm, ar1, ew, er);
        chk("post_rst_status", rd, 32'h0000_0004);
        chk("post_rst_latency", lat, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
